uart_host_bridge: RTL and testbench
===================================

Name: uart_host_bridge

Overview:
- Avalon-MM initiator that drives the register-slave port of the team's UART core. The UART core is the responder; this block is the initiator.
- Performs the init sequence, then polls the status register. Moves received bytes to a valid/ready byte stream and writes stream bytes into the UART TX register.
- Sits between the RISC-V core's byte-stream peripherals (console, loader) and the UART core, so no CPU software is needed for the UART.

Parameters:
- ACC_CYCLES, 2, cycles each bus access holds chipselect/strobe (1 = zero wait states); readdata sampled on the last one.
- POLL_GAP, 4, idle cycles between consecutive status polls.
- INIT_DIVISOR, 16'd434, baud divisor written to register 4 at init.
- WRITE_DIVISOR, 1, 1 = write the divisor register at init; 0 = skip (fixed-baud core).

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- wire_address  out  3  UART register address (0 rxdata, 1 txdata, 2 status, 3 control, 4 divisor)
- wire_begintransfer  out  1  high on the first cycle of each access only
- wire_chipselect  out  1  high for the whole access
- wire_read_n  out  1  active-low read strobe
- wire_write_n  out  1  active-low write strobe
- wire_writedata  out  16  write data
- wire_readdata  in  16  read data from the UART
- int_irq  in  1  UART interrupt; when high, the POLL_GAP wait is cut short
- tx_data  in  8  byte to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  TX holding register empty
- rx_data  out  8  received byte
- rx_valid  out  1  rx_data valid
- rx_ready  in  1  consumer accepts rx_data
- err_flags  out  4  sticky {TOE, ROE, FE, PE}; cleared only by reset
- init_done  out  1  high once the init sequence completes

Behaviour:
- Reset (asynchronous, any state including mid-access):
  - address = 0, writedata = 0, begintransfer = 0, chipselect = 0, read_n = 1, write_n = 1.
  - tx_ready = 0, rx_valid = 0, rx_data = 0, err_flags = 0, init_done = 0.
  - FSM goes to INIT_DIV.
- Access timing: address, writedata and strobes are registered outputs, stable for exactly ACC_CYCLES cycles. Read data is captured on the last cycle. After each access there is one cycle with chipselect = 0 before the next. No back-to-back accesses.
- FSM states:
  - INIT_DIV: write INIT_DIVISOR to address 4. Skipped if WRITE_DIVISOR = 0.
  - INIT_CTL: write 0 to address 3 (all interrupt enables off).
  - INIT_CLR: write 0 to address 2 (clear status). On completion, init_done goes to 1.
  - IDLE: count POLL_GAP cycles, then go to RD_STAT. If int_irq = 1, go to RD_STAT on the next cycle.
  - RD_STAT: read address 2; latch status S.
  - DECIDE (1 cycle), priority order:
    1. Any of S[4] TOE, S[3] ROE, S[1] FE, S[0] PE set: OR them into err_flags, go to CLR_ERR.
    2. S[7] RRDY = 1 and rx_valid = 0: go to RD_RX.
    3. S[6] TRDY = 1 and TX holding register full: go to WR_TX.
    4. Otherwise go to IDLE.
  - CLR_ERR: write 0 to address 2, then re-enter DECIDE using the latched S with its error bits masked.
  - RD_RX: read address 0. rx_data = readdata[7:0]; rx_valid = 1 the cycle after the sample. Return to IDLE.
  - WR_TX: write {8'h00, tx_hold} to address 1. The TX holding register frees on the last access cycle. Return to IDLE.
- RX output stage:
  - One-entry register; rx_valid holds until the rx_valid & rx_ready cycle.
  - While rx_valid = 1, RRDY is ignored. UART overrun can then occur and is reported via ROE.
- TX input stage:
  - One-entry holding register. tx_ready = init_done & empty.
  - A tx_valid & tx_ready cycle captures tx_data.
  - A capture and a free in the same cycle cannot occur: tx_ready is 0 while the register is full.
- RX is always served before TX when both are ready. Each status poll serves at most one of RX or TX.
- err_flags bits never clear without reset.

Test Plan:
- Reset, then release with WRITE_DIVISOR = 1 -> writes (addr 4, 0x01B2), (addr 3, 0x0000), (addr 2, 0x0000), each ACC_CYCLES long; begintransfer asserted 1 cycle per access; init_done = 1 after the third write.
- Status 0x0040, tx_valid with tx_data 0xA5 -> within one poll, a write of 0x00A5 to addr 1; tx_ready returns to 1.
- Status 0x0080, rxdata 0x013C -> a read of addr 0; rx_data = 0x3C, rx_valid = 1; it holds until rx_ready is asserted.
- rx_valid held (rx_ready = 0), status 0x0080 repeatedly -> no addr 0 read issued; a later status 0x0088 -> err_flags = 4'b0100 and a 0 written to addr 2.
- Status 0x00C0 with TX pending -> addr 0 read first, addr 1 write on a later poll; the TX byte is not lost.
- Reset asserted mid-access (chipselect high) -> all bus outputs go to their reset values immediately (asynchronous); after release the init sequence restarts.

Source files
------------

// File: rtl/uart_host_bridge.sv
// -----------------------------------------------------------------------------
// uart_host_bridge
//
// Avalon-MM initiator for the UART core's register-slave port. After reset it
// programs the UART (divisor, control, status clear), then polls the status
// register and moves bytes between the UART and a pair of valid/ready byte
// streams, so the UART runs without any CPU software.
//
// Parameters:
//   ACC_CYCLES    cycles each bus access holds chipselect/strobe (>= 1)
//   POLL_GAP      idle cycles between consecutive status polls
//   INIT_DIVISOR  baud divisor written to register 4 at init
//   WRITE_DIVISOR 1 = program the divisor at init, 0 = skip it
//
// Ports:
//   clk_clk, reset_reset_n      clock, asynchronous active-low reset
//   wire_*                      Avalon-MM initiator towards the UART core
//   int_irq                     UART interrupt; shortens the poll gap
//   tx_data/tx_valid/tx_ready   byte stream into the UART transmitter
//   rx_data/rx_valid/rx_ready   byte stream out of the UART receiver
//   err_flags                   sticky {TOE, ROE, FE, PE}
//   init_done                   high once the init sequence has completed
// -----------------------------------------------------------------------------
module uart_host_bridge #(
  parameter int          ACC_CYCLES    = 2,
  parameter int          POLL_GAP      = 4,
  parameter logic [15:0] INIT_DIVISOR  = 16'd434,
  parameter int          WRITE_DIVISOR = 1
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  output logic [2:0]  wire_address,
  output logic        wire_begintransfer,
  output logic        wire_chipselect,
  output logic        wire_read_n,
  output logic        wire_write_n,
  output logic [15:0] wire_writedata,
  input  logic [15:0] wire_readdata,
  input  logic        int_irq,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [3:0]  err_flags,
  output logic        init_done
);

  // UART register map
  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;
  localparam logic [2:0] ADDR_DIVISOR = 3'd4;

  // Status bits that report errors: TOE, ROE, FE, PE
  localparam logic [7:0] STAT_ERR_MASK = 8'h1B;

  localparam int CW       = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
  localparam int GAP_EFF  = (POLL_GAP > 1) ? POLL_GAP : 1;
  localparam int GW       = (GAP_EFF > 1) ? $clog2(GAP_EFF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_EFF - 1);

  typedef enum logic [3:0] {
    S_INIT_DIV,
    S_INIT_CTL,
    S_INIT_CLR,
    S_IDLE,
    S_RD_STAT,
    S_DECIDE,
    S_CLR_ERR,
    S_RD_RX,
    S_WR_TX
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [GW-1:0] r_gap;
  logic [2:0]    r_address;
  logic [15:0]   r_writedata;
  logic          r_begin;
  logic          r_cs;
  logic          r_read_n;
  logic          r_write_n;
  logic [7:0]    r_stat;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic [7:0]    r_tx_hold;
  logic          r_tx_full;
  logic [3:0]    r_err;
  logic          r_init_done;

  logic          w_acc_state;
  logic [2:0]    w_acc_addr;
  logic [15:0]   w_acc_wdata;
  logic          w_acc_read;
  logic          w_acc_done;
  logic          w_tx_ready;
  logic [3:0]    w_err_bits;
  logic          w_unused;

  // Which bus access the current state performs.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_acc_state = 1'b1;
    w_acc_addr  = ADDR_RXDATA;
    w_acc_wdata = 16'h0000;
    w_acc_read  = 1'b0;
    case (r_state)
      S_INIT_DIV: begin
        w_acc_state = (WRITE_DIVISOR != 0);
        w_acc_addr  = ADDR_DIVISOR;
        w_acc_wdata = INIT_DIVISOR;
      end
      S_INIT_CTL: w_acc_addr = ADDR_CONTROL;
      S_INIT_CLR: w_acc_addr = ADDR_STATUS;
      S_CLR_ERR:  w_acc_addr = ADDR_STATUS;
      S_RD_STAT: begin
        w_acc_addr = ADDR_STATUS;
        w_acc_read = 1'b1;
      end
      S_RD_RX: begin
        w_acc_addr = ADDR_RXDATA;
        w_acc_read = 1'b1;
      end
      S_WR_TX: begin
        w_acc_addr  = ADDR_TXDATA;
        w_acc_wdata = {8'h00, r_tx_hold};
      end
      default: w_acc_state = 1'b0;
    endcase
  end

  // High during the final cycle of an access; readdata is sampled at its end.
  assign w_acc_done = r_cs && (r_cnt == CNT_LAST);
  assign w_tx_ready = r_init_done && !r_tx_full;
  assign w_err_bits = {r_stat[4], r_stat[3], r_stat[1], r_stat[0]};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state     <= S_INIT_DIV;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_address   <= 3'd0;
      r_writedata <= 16'h0000;
      r_begin     <= 1'b0;
      r_cs        <= 1'b0;
      r_read_n    <= 1'b1;
      r_write_n   <= 1'b1;
      r_stat      <= 8'h00;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_tx_hold   <= 8'h00;
      r_tx_full   <= 1'b0;
      r_err       <= 4'h0;
      r_init_done <= 1'b0;
    end else begin
      r_begin <= 1'b0;

      // Bus sequencer. An access state spends one cycle with chipselect low
      // (the mandatory gap), then holds the access for ACC_CYCLES cycles.
      if (w_acc_state) begin
        if (!r_cs) begin
          r_cs        <= 1'b1;
          r_begin     <= 1'b1;
          r_cnt       <= '0;
          r_address   <= w_acc_addr;
          r_writedata <= w_acc_wdata;
          r_read_n    <= !w_acc_read;
          r_write_n   <= w_acc_read;
        end else if (!w_acc_done) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cs      <= 1'b0;
          r_read_n  <= 1'b1;
          r_write_n <= 1'b1;
        end
      end

      // Stream handshakes; the FSM below may override r_rx_valid when it
      // loads a new byte (only possible while r_rx_valid is already 0).
      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
      if (tx_valid && w_tx_ready) begin
        r_tx_hold <= tx_data;
        r_tx_full <= 1'b1;
      end

      case (r_state)
        S_INIT_DIV: if (WRITE_DIVISOR == 0 || w_acc_done) r_state <= S_INIT_CTL;
        S_INIT_CTL: if (w_acc_done) r_state <= S_INIT_CLR;
        S_INIT_CLR: begin
          if (w_acc_done) begin
            r_init_done <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (int_irq || r_gap >= GAP_LAST) begin
            r_gap   <= '0;
            r_state <= S_RD_STAT;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        S_RD_STAT: begin
          if (w_acc_done) begin
            r_stat  <= wire_readdata[7:0];
            r_state <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          if (|w_err_bits) begin
            r_err   <= r_err | w_err_bits;
            r_state <= S_CLR_ERR;
          end else if (r_stat[7] && !r_rx_valid) begin
            r_state <= S_RD_RX;
          end else if (r_stat[6] && r_tx_full) begin
            r_state <= S_WR_TX;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CLR_ERR: begin
          // Re-decide on the same poll with the error bits now handled.
          if (w_acc_done) begin
            r_stat  <= r_stat & ~STAT_ERR_MASK;
            r_state <= S_DECIDE;
          end
        end
        S_RD_RX: begin
          if (w_acc_done) begin
            r_rx_data  <= wire_readdata[7:0];
            r_rx_valid <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        S_WR_TX: begin
          if (w_acc_done) begin
            r_tx_full <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_INIT_DIV;
      endcase
    end
  end

  // Status bits 5 and 2 and the upper readdata byte carry nothing we act on.
  assign w_unused = ^{wire_readdata[15:8], r_stat[5], r_stat[2]};

  assign wire_address       = r_address;
  assign wire_begintransfer = r_begin;
  assign wire_chipselect    = r_cs;
  assign wire_read_n        = r_read_n;
  assign wire_write_n       = r_write_n;
  assign wire_writedata     = r_writedata;
  assign tx_ready           = w_tx_ready;
  assign rx_data            = r_rx_data;
  assign rx_valid           = r_rx_valid;
  assign err_flags          = r_err;
  assign init_done          = r_init_done;

endmodule

// File: tb/tb_uart_host_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_host_bridge
//
// Scoreboard bench for uart_host_bridge. The stimulus process pushes the bus
// accesses and RX bytes it expects; a monitor process watches the Avalon bus
// and the RX stream, emulates the UART register side effects, and compares.
// Status polls (reads of address 2) are checked for timing only.
// -----------------------------------------------------------------------------
module tb_uart_host_bridge;

  localparam int ACC = 2;

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_t;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b1;
  logic [2:0]  wire_address;
  logic        wire_begintransfer;
  logic        wire_chipselect;
  logic        wire_read_n;
  logic        wire_write_n;
  logic [15:0] wire_writedata;
  logic [15:0] wire_readdata;
  logic        int_irq = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [3:0]  err_flags;
  logic        init_done;

  logic [15:0] status_reg = 16'h0000;
  logic [15:0] rxdata_reg = 16'h0000;

  bus_t        exp_q[$];
  logic [7:0]  rx_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_rx_reads = 0;

  uart_host_bridge #(
    .ACC_CYCLES(ACC), .POLL_GAP(4), .INIT_DIVISOR(16'd434), .WRITE_DIVISOR(1)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .wire_address(wire_address),
    .wire_begintransfer(wire_begintransfer),
    .wire_chipselect(wire_chipselect),
    .wire_read_n(wire_read_n),
    .wire_write_n(wire_write_n),
    .wire_writedata(wire_writedata),
    .wire_readdata(wire_readdata),
    .int_irq(int_irq),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .err_flags(err_flags),
    .init_done(init_done)
  );

  always #5 clk_clk = ~clk_clk;

  // UART register read port
  assign wire_readdata = (wire_chipselect && !wire_read_n) ?
                         ((wire_address == 3'd2) ? status_reg :
                          (wire_address == 3'd0) ? rxdata_reg : 16'h0000) : 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_bus(input bit wr, input logic [2:0] addr, input logic [15:0] data);
    bus_t e;
    e.wr = wr;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_bus(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk_clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic send_tx(input logic [7:0] b);
    int n = 0;
    @(posedge clk_clk); #1;
    while (!tx_ready && n < 200) begin
      @(posedge clk_clk); #1;
      n++;
    end
    check("tx_ready_before_send", 32'(tx_ready), 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk_clk); #1;
    tx_valid = 1'b0;
    check("tx_ready_while_full", 32'(tx_ready), 32'd0);
  endtask

  task automatic consume_rx();
    @(posedge clk_clk); #1;
    rx_ready = 1'b1;
    @(posedge clk_clk); #1;
    rx_ready = 1'b0;
    check("rx_valid_after_accept", 32'(rx_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_address"},       32'(wire_address), 32'd0);
    check({tag, "_writedata"},     32'(wire_writedata), 32'd0);
    check({tag, "_begintransfer"}, 32'(wire_begintransfer), 32'd0);
    check({tag, "_chipselect"},    32'(wire_chipselect), 32'd0);
    check({tag, "_read_n"},        32'(wire_read_n), 32'd1);
    check({tag, "_write_n"},       32'(wire_write_n), 32'd1);
    check({tag, "_tx_ready"},      32'(tx_ready), 32'd0);
    check({tag, "_rx_valid"},      32'(rx_valid), 32'd0);
    check({tag, "_rx_data"},       32'(rx_data), 32'd0);
    check({tag, "_err_flags"},     32'(err_flags), 32'd0);
    check({tag, "_init_done"},     32'(init_done), 32'd0);
  endtask

  // Monitor: bus access timing, scoreboard compare, UART side effects, RX stream.
  initial begin : monitor
    logic        prev_cs;
    logic [2:0]  cur_addr;
    logic        cur_wr, cur_rd, bt_ok, stable;
    logic [15:0] cur_data;
    int          len;
    bus_t        e;
    prev_cs = 1'b0;
    cur_addr = 3'd0; cur_wr = 1'b0; cur_rd = 1'b0; cur_data = 16'h0;
    bt_ok = 1'b0; stable = 1'b0; len = 0;
    forever begin
      @(negedge clk_clk);
      if (!reset_reset_n) begin
        prev_cs = 1'b0;
      end else begin
        if (wire_chipselect) begin
          if (!prev_cs) begin
            cur_addr = wire_address;
            cur_wr   = !wire_write_n;
            cur_rd   = !wire_read_n;
            cur_data = wire_writedata;
            len      = 1;
            bt_ok    = wire_begintransfer;
            stable   = (cur_wr != cur_rd);
          end else begin
            len++;
            if (wire_begintransfer) bt_ok = 1'b0;
            if (wire_address != cur_addr || (!wire_write_n) != cur_wr ||
                (!wire_read_n) != cur_rd || wire_writedata != cur_data) stable = 1'b0;
          end
        end else if (prev_cs) begin
          check("acc_length", 32'(len), 32'(ACC));
          check("acc_begintransfer_first_only", 32'(bt_ok), 32'd1);
          check("acc_stable", 32'(stable), 32'd1);
          if (!(cur_rd && cur_addr == 3'd2)) begin
            if (exp_q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_access: got wr=%0b addr=%0d data=0x%0h, expected none",
                       cur_wr, cur_addr, cur_data);
            end else begin
              e = exp_q.pop_front();
              check("bus_write", 32'(cur_wr), 32'(e.wr));
              check("bus_addr", 32'(cur_addr), 32'(e.addr));
              if (e.wr) check("bus_wdata", 32'(cur_data), 32'(e.data));
            end
          end
          if (cur_rd && cur_addr == 3'd0) begin
            n_rx_reads++;
            status_reg[7] = 1'b0;
          end
          if (cur_wr && cur_addr == 3'd2) status_reg = status_reg & ~16'h001B;
        end
        prev_cs = wire_chipselect;
        if (rx_valid && rx_ready) begin
          if (rx_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rx_byte: got 0x%0h, expected none", rx_data);
          end else begin
            check("rx_byte", 32'(rx_data), 32'(rx_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int n;
    int rx_reads_before;

    // Reset state
    #2 reset_reset_n = 1'b0;
    repeat (3) @(negedge clk_clk);
    check_reset_outputs("reset");

    // Init sequence: divisor 434 = 0x01B2, control 0, status clear
    push_bus(1'b1, 3'd4, 16'h01B2);
    push_bus(1'b1, 3'd3, 16'h0000);
    push_bus(1'b1, 3'd2, 16'h0000);
    reset_reset_n = 1'b1;
    wait_bus("init_sequence_done", 200);
    check("init_done_after_init", 32'(init_done), 32'd1);
    check("tx_ready_after_init", 32'(tx_ready), 32'd1);

    // TX: TRDY set, byte 0xA5 written to address 1
    status_reg = 16'h0040;
    push_bus(1'b1, 3'd1, 16'h00A5);
    send_tx(8'hA5);
    wait_bus("tx_a5_written", 100);
    repeat (2) @(negedge clk_clk);
    check("tx_ready_after_write", 32'(tx_ready), 32'd1);

    // RX: RRDY set, rxdata 0x013C -> byte 0x3C held until accepted
    rxdata_reg = 16'h013C;
    push_bus(1'b0, 3'd0, 16'h0000);
    rx_q.push_back(8'h3C);
    status_reg = 16'h0080;
    wait_bus("rx_3c_read", 100);
    repeat (30) @(negedge clk_clk);
    check("rx_valid_held", 32'(rx_valid), 32'd1);
    check("rx_data_held", 32'(rx_data), 32'h3C);
    consume_rx();

    // Overrun: RX stage full, RRDY ignored; ROE then reported and cleared
    rxdata_reg = 16'h0155;
    push_bus(1'b0, 3'd0, 16'h0000);
    rx_q.push_back(8'h55);
    status_reg = 16'h0080;
    wait_bus("rx_55_read", 100);
    rx_reads_before = n_rx_reads;
    status_reg = 16'h0080;
    repeat (60) @(negedge clk_clk);
    check("no_rx_read_while_full", 32'(n_rx_reads - rx_reads_before), 32'd0);
    check("err_flags_before_roe", 32'(err_flags), 32'd0);
    push_bus(1'b1, 3'd2, 16'h0000);
    status_reg = 16'h0088;
    wait_bus("roe_status_cleared", 100);
    check("err_flags_roe", 32'(err_flags), 32'h4);
    status_reg = 16'h0000;
    repeat (20) @(negedge clk_clk);
    consume_rx();

    // RX and TX both ready: RX read first, TX write on a later poll
    send_tx(8'h5A);
    rxdata_reg = 16'h0177;
    push_bus(1'b0, 3'd0, 16'h0000);
    push_bus(1'b1, 3'd1, 16'h005A);
    rx_q.push_back(8'h77);
    status_reg = 16'h00C0;
    wait_bus("rx_then_tx", 200);
    repeat (2) @(negedge clk_clk);
    check("tx_ready_after_both", 32'(tx_ready), 32'd1);
    check("rx_data_77", 32'(rx_data), 32'h77);
    consume_rx();
    check("err_flags_sticky", 32'(err_flags), 32'h4);

    // Reset asserted in the middle of an access
    n = 0;
    do begin
      @(posedge clk_clk); #1;
      n++;
    end while (!wire_chipselect && n < 100);
    check("mid_access_cs_seen", 32'(wire_chipselect), 32'd1);
    reset_reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    status_reg = 16'h0000;
    repeat (3) @(negedge clk_clk);
    push_bus(1'b1, 3'd4, 16'h01B2);
    push_bus(1'b1, 3'd3, 16'h0000);
    push_bus(1'b1, 3'd2, 16'h0000);
    reset_reset_n = 1'b1;
    wait_bus("reinit_sequence_done", 200);
    check("init_done_after_reinit", 32'(init_done), 32'd1);

    repeat (20) @(negedge clk_clk);
    check("rx_queue_drained", 32'(rx_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
